// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and an optional return address stack.
// The return address stack is built only when BRANCH_PREDICTOR_RAS_EN is defined.
module branch_predictor #(
    parameter int GHR_SIZE       = 5,
    parameter int BHT_INDEX_BITS = 6,
    parameter int BTB_INDEX_BITS = 5,
    parameter int BTB_TAG_BITS   = 8,
    parameter int RAS_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      lookup_valid,
    input  logic [31:0]               lookup_pc,
    input  logic                      lookup_is_compressed,
    input  logic                      lookup_is_cond,
    input  logic                      lookup_is_uncond,
    input  logic                      lookup_is_call,
    input  logic                      lookup_is_return,
    input  logic                      update_valid,
    input  logic [31:0]               update_pc,
    input  logic                      update_is_cond,
    input  logic                      update_taken,
    input  logic [31:0]               update_target,
    input  logic [BHT_INDEX_BITS-1:0] update_index,
    input  logic [GHR_SIZE-1:0]       update_ghr,
    input  logic                      mispredict,
    output logic                      pred_taken,
    output logic [31:0]               pred_target,
    output logic [GHR_SIZE-1:0]       pred_ghr,
    output logic [BHT_INDEX_BITS-1:0] pred_index
);
    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_LSB     = BTB_INDEX_BITS + 1;
    localparam int TAG_MSB     = BTB_INDEX_BITS + BTB_TAG_BITS;

    logic [GHR_SIZE-1:0]     ghr_q, ghr_d;
    logic [1:0]              bht_q        [BHT_ENTRIES];
    logic                    btb_valid_q  [BTB_ENTRIES];
    logic [BTB_TAG_BITS-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [31:0]             btb_target_q [BTB_ENTRIES];

    logic [BTB_INDEX_BITS-1:0] lk_btb_idx;
    logic [BTB_TAG_BITS-1:0]   lk_btb_tag;
    logic [BTB_INDEX_BITS-1:0] up_btb_idx;
    logic                      btb_hit;
    logic                      btb_taken;
    logic [31:0]               seq_pc;
    logic                      ras_hit;
    logic [31:0]               ras_top;
    logic                      unused_upd;

    assign lk_btb_idx = lookup_pc[BTB_INDEX_BITS:1];
    assign lk_btb_tag = lookup_pc[TAG_MSB:TAG_LSB];
    assign up_btb_idx = update_pc[BTB_INDEX_BITS:1];
    assign unused_upd = ^{update_pc[31:TAG_MSB+1], update_pc[0]};

    assign btb_hit    = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_btb_tag);
    assign pred_index = lookup_pc[BHT_INDEX_BITS:1] ^ BHT_INDEX_BITS'(ghr_q);
    assign btb_taken  = btb_hit && (lookup_is_uncond || (lookup_is_cond && bht_q[pred_index][1]));
    assign seq_pc     = lookup_pc + (lookup_is_compressed ? 32'd2 : 32'd4);
    assign pred_ghr   = ghr_q;

    // A valid return address on the stack outranks whatever the BTB holds.
    always_comb begin
        pred_taken  = lookup_valid && (ras_hit || btb_taken);
        pred_target = seq_pc;
        if (pred_taken) begin
            pred_target = ras_hit ? ras_top : btb_target_q[lk_btb_idx];
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = update_is_cond ? {update_ghr[GHR_SIZE-2:0], update_taken} : update_ghr;
        end else if (lookup_valid && lookup_is_cond) begin
            ghr_d = {ghr_q[GHR_SIZE-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (update_valid && update_is_cond) begin
            if (update_taken && (bht_q[update_index] != 2'b11)) begin
                bht_q[update_index] <= bht_q[update_index] + 2'd1;
            end else if (!update_taken && (bht_q[update_index] != 2'b00)) begin
                bht_q[update_index] <= bht_q[update_index] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else if (update_valid && update_taken) begin
            btb_valid_q[up_btb_idx]  <= 1'b1;
            btb_tag_q[up_btb_idx]    <= update_pc[TAG_MSB:TAG_LSB];
            btb_target_q[up_btb_idx] <= update_target;
        end
    end

`ifdef BRANCH_PREDICTOR_RAS_EN
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
    localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]          ras_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_top_q, ras_top_d;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [RAS_PTR_W-1:0] ras_wr_ptr;
    logic                 ras_wr;
    logic                 ras_push;

    assign ras_top  = ras_q[ras_top_q];
    assign ras_hit  = lookup_valid && lookup_is_return && (ras_cnt_q != '0);
    assign ras_push = lookup_valid && lookup_is_call;

    // Pushing when full lets the pointer wrap over the oldest entry; count stays saturated.
    always_comb begin
        ras_top_d  = ras_top_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr     = 1'b0;
        ras_wr_ptr = ras_top_q + RAS_PTR_W'(1);
        if (mispredict) begin
            ras_cnt_d = '0;
        end else if (ras_push && ras_hit) begin
            ras_wr     = 1'b1;
            ras_wr_ptr = ras_top_q;
        end else if (ras_push) begin
            ras_wr    = 1'b1;
            ras_top_d = ras_top_q + RAS_PTR_W'(1);
            if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
            end
        end else if (ras_hit) begin
            ras_top_d = ras_top_q - RAS_PTR_W'(1);
            ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_top_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            ras_top_q <= ras_top_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_wr) begin
                ras_q[ras_wr_ptr] <= seq_pc;
            end
        end
    end
`else
    logic unused_ras;

    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign unused_ras = ^{lookup_is_call, lookup_is_return, RAS_DEPTH[0]};
`endif

endmodule
